vga_ctrl_param: RTL and testbench



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_ctrl_param_test_pattern.sv | 28 ++
 rtl/vga_ctrl_param.sv | 143 ++++++++++++++
 tb/tb_vga_ctrl_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, RGB565 colours and the colour-bar table.
package vga_pkg;

    // 640x480@60 timing (pixel clocks / lines)
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BACK  = 48;
    localparam int unsigned VGA_H_VALID = 640;
    localparam int unsigned VGA_H_FRONT = 16;
    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BACK  = 33;
    localparam int unsigned VGA_V_VALID = 480;
    localparam int unsigned VGA_V_FRONT = 10;

    // Counter width; both totals must fit in it
    localparam int unsigned CNT_W    = 12;
    localparam int unsigned COLOUR_W = 16;
    localparam int unsigned NUM_BARS = 8;

    // RGB565 colours
    localparam logic [COLOUR_W-1:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [COLOUR_W-1:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [COLOUR_W-1:0] RGB_CYAN    = 16'h07FF;
    localparam logic [COLOUR_W-1:0] RGB_GREEN   = 16'h07E0;
    localparam logic [COLOUR_W-1:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [COLOUR_W-1:0] RGB_RED     = 16'hF800;
    localparam logic [COLOUR_W-1:0] RGB_BLUE    = 16'h001F;
    localparam logic [COLOUR_W-1:0] RGB_BLACK   = 16'h0000;

    // Bar colours, index 0 = leftmost bar
    localparam logic [NUM_BARS-1:0][COLOUR_W-1:0] BAR_TABLE = {
        RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
        RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
    };

endpackage

// File: rtl/vga_ctrl_param_test_pattern.sv
// Eight equal-width vertical colour bars indexed by the de-aligned x coordinate.
module vga_test_pattern
    import vga_pkg::*;
#(
    parameter int unsigned H_VALID = VGA_H_VALID,
    parameter int unsigned XY_W    = 10,
    parameter int unsigned RGB_W   = COLOUR_W
) (
    input  logic [XY_W-1:0]  x,
    output logic [RGB_W-1:0] colour
);

    localparam int unsigned BAR_W = H_VALID / NUM_BARS;

    logic [XY_W-1:0] bar_full;
    logic [2:0]      bar_idx;

    // Bar index from x, saturated so off-screen x never indexes past the table
    always_comb begin
        bar_full = x / XY_W'(BAR_W);
        bar_idx  = 3'd7;
        if (bar_full <= XY_W'(NUM_BARS - 1)) begin
            bar_idx = bar_full[2:0];
        end
        colour = RGB_W'(BAR_TABLE[bar_idx]);
    end

endmodule

// File: rtl/vga_ctrl_param.sv
// Parameterised VGA timing controller: counters, sync/de/request decode, colour mux.
module vga_ctrl_param
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned H_VALID  = VGA_H_VALID,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter int unsigned V_VALID  = VGA_V_VALID,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned RGB_W    = COLOUR_W,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned XY_W     = 10
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [RGB_W-1:0] pix_data,
    input  logic             blank,
    input  logic             pattern_en,
    output logic             pix_req,
    output logic [XY_W-1:0]  pix_x,
    output logic [XY_W-1:0]  pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int unsigned HS      = H_SYNC + H_BACK;
    localparam int unsigned VS      = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HS_C     = CNT_W'(HS);
    localparam logic [CNT_W-1:0] HE_C     = CNT_W'(HS + H_VALID);
    localparam logic [CNT_W-1:0] REQ_S_C  = CNT_W'(HS - 1);
    localparam logic [CNT_W-1:0] REQ_E_C  = CNT_W'(HS + H_VALID - 1);
    localparam logic [CNT_W-1:0] VS_C     = CNT_W'(VS);
    localparam logic [CNT_W-1:0] VE_C     = CNT_W'(VS + V_VALID);

    // Reject timings the counters or coordinates cannot represent
    generate
        if ((H_VALID % NUM_BARS) != 0) begin : g_bad_hvalid_div
            $error("H_VALID must be divisible by 8");
        end
        if (H_TOTAL > (1 << CNT_W)) begin : g_bad_htotal
            $error("H_TOTAL exceeds 2^12");
        end
        if (V_TOTAL > (1 << CNT_W)) begin : g_bad_vtotal
            $error("V_TOTAL exceeds counter range");
        end
        if (H_VALID > ((1 << XY_W) - 1)) begin : g_bad_hvalid_w
            $error("H_VALID exceeds 2^XY_W-1");
        end
        if (V_VALID > ((1 << XY_W) - 1)) begin : g_bad_vvalid_w
            $error("V_VALID exceeds 2^XY_W-1");
        end
        if (HS < 1) begin : g_bad_hs
            $error("H_SYNC+H_BACK must be at least 1 for the request lead");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             in_rst;
    logic             pattern_q;
    logic             hs_act;
    logic             vs_act;
    logic             v_win;
    logic [XY_W-1:0]  bar_x;
    logic [RGB_W-1:0] bar_colour;

    // Frame counters; held at 0,0 for one cycle after reset so that cycle shows frame start
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            in_rst    <= 1'b1;
            pattern_q <= 1'b0;
        end else begin
            in_rst <= 1'b0;
            if (!in_rst) begin
                if (h_cnt == H_LAST_C) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
            if (frame_start) begin
                pattern_q <= pattern_en;
            end
        end
    end

    // Timing decode from the registered counters; all inactive while in reset
    always_comb begin
        hs_act      = 1'b0;
        vs_act      = 1'b0;
        v_win       = 1'b0;
        de          = 1'b0;
        pix_req     = 1'b0;
        frame_start = 1'b0;
        if (!in_rst) begin
            hs_act      = (h_cnt < H_SYNC_C);
            vs_act      = (v_cnt < V_SYNC_C);
            v_win       = (v_cnt >= VS_C) && (v_cnt < VE_C);
            de          = v_win && (h_cnt >= HS_C) && (h_cnt < HE_C);
            pix_req     = v_win && (h_cnt >= REQ_S_C) && (h_cnt < REQ_E_C);
            frame_start = (h_cnt == '0) && (v_cnt == '0);
        end
        hsync = SYNC_POL ? hs_act : !hs_act;
        vsync = SYNC_POL ? vs_act : !vs_act;
        pix_x = pix_req ? XY_W'(h_cnt - REQ_S_C) : '1;
        pix_y = pix_req ? XY_W'(v_cnt - VS_C) : '1;
        bar_x = XY_W'(h_cnt - HS_C);
    end

    vga_test_pattern #(
        .H_VALID (H_VALID),
        .XY_W    (XY_W),
        .RGB_W   (RGB_W)
    ) u_pattern (
        .x      (bar_x),
        .colour (bar_colour)
    );

    // Output colour: black outside de or when blanked, else bars or user pixel
    always_comb begin
        rgb = '0;
        if (de && !blank) begin
            rgb = pattern_q ? bar_colour : pix_data;
        end
    end

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Directed bench for vga_ctrl_param at 640x480@60 defaults.
module tb_vga_ctrl_param;

    localparam int H_TOT = 800;
    localparam int V_TOT = 525;
    localparam int FRAME = H_TOT * V_TOT;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] pix_data = 16'hFFFF;
    logic        blank = 1'b0;
    logic        pattern_en = 1'b0;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_start;

    int tests = 0;
    int fails = 0;
    int hm = 0;
    int vm = 0;
    bit track = 1'b0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    vga_ctrl_param dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .pix_data    (pix_data),
        .blank       (blank),
        .pattern_en  (pattern_en),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock, sample 1 time unit after the edge, track expected position
    task automatic tick();
        @(posedge vga_clk);
        #1;
        if (track) begin
            if (hm == H_TOT - 1) begin
                hm = 0;
                vm = (vm == V_TOT - 1) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int guard = 0;
        while (!(hm == h && vm == v) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        track = 1'b0;
        repeat (3) begin
            tick();
            tests++;
            if ({hsync, vsync, de, pix_req, frame_start, pix_x, pix_y, rgb} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000}) begin
                fails++;
                $display("FAIL reset_values: hs=%b vs=%b de=%b req=%b fs=%b x=%h y=%h rgb=%h, want 1 1 0 0 0 3ff 3ff 0000",
                         hsync, vsync, de, pix_req, frame_start, pix_x, pix_y, rgb);
            end
        end
        sys_rst = 1'b0;
        tick();
        hm = 0;
        vm = 0;
        track = 1'b1;
        tests++;
        if ({frame_start, hsync, vsync, de, pix_req} !== 5'b10000) begin
            fails++;
            $display("FAIL first_after_reset: fs/hs/vs/de/req=%b want 10000",
                     {frame_start, hsync, vsync, de, pix_req});
        end
    endtask

    // Two full frames: sync widths, frame period, de/req/xy/rgb window, line 35 edges
    task automatic test_frame_timing();
        int hs_low = 0;
        int bad_hlines = 0;
        int vs_lines = 0;
        int sig_err = 0;
        int err_h = 0;
        int err_v = 0;
        int fs_count = 0;
        int last_fs = -1;
        bit vwin;
        bit e_de;
        bit e_req;
        logic [9:0]  e_px;
        logic [9:0]  e_py;
        logic [15:0] e_rgb;
        logic [14:0] l35_obs;
        logic [14:0] l35_exp;
        for (int n = 0; n < 2 * FRAME; n++) begin
            vwin  = (vm >= 35) && (vm < 515);
            e_de  = vwin && (hm >= 144) && (hm < 784);
            e_req = vwin && (hm >= 143) && (hm < 783);
            e_px  = e_req ? 10'(hm - 143) : 10'h3FF;
            e_py  = e_req ? 10'(vm - 35) : 10'h3FF;
            e_rgb = e_de ? 16'hFFFF : 16'h0000;
            if ({hsync, vsync, de, pix_req, frame_start, pix_x, pix_y, rgb} !==
                {(hm >= 96), (vm >= 2), e_de, e_req, (hm == 0 && vm == 0), e_px, e_py, e_rgb}) begin
                if (sig_err == 0) begin
                    err_h = hm;
                    err_v = vm;
                end
                sig_err++;
            end
            if (hsync === 1'b0) hs_low++;
            if (hm == H_TOT - 1) begin
                if (hs_low != 96) bad_hlines++;
                hs_low = 0;
            end
            if (hm == 0 && vsync === 1'b0) vs_lines++;
            if (hm == H_TOT - 1 && vm == V_TOT - 1) begin
                tests++;
                if (vs_lines != 2) begin
                    fails++;
                    $display("FAIL vsync_lines: got %0d low lines, want 2", vs_lines);
                end
                vs_lines = 0;
            end
            if (frame_start === 1'b1) begin
                fs_count++;
                last_fs = n;
            end
            if (n < FRAME && vm == 35 &&
                (hm == 142 || hm == 143 || hm == 144 || hm == 782 || hm == 783 || hm == 784)) begin
                l35_obs = {pix_req, de, 3'b000, pix_x};
                case (hm)
                    142:     l35_exp = {1'b0, 1'b0, 3'b000, 10'h3FF};
                    143:     l35_exp = {1'b1, 1'b0, 3'b000, 10'd0};
                    144:     l35_exp = {1'b1, 1'b1, 3'b000, 10'd1};
                    782:     l35_exp = {1'b1, 1'b1, 3'b000, 10'd639};
                    783:     l35_exp = {1'b0, 1'b1, 3'b000, 10'h3FF};
                    default: l35_exp = {1'b0, 1'b0, 3'b000, 10'h3FF};
                endcase
                tests++;
                if (l35_obs !== l35_exp) begin
                    fails++;
                    $display("FAIL line35_h%0d: req=%b de=%b x=%0d, want req=%b de=%b x=%0d",
                             hm, pix_req, de, pix_x, l35_exp[14], l35_exp[13], l35_exp[9:0]);
                end
            end
            // Mid-frame request for pattern mode; must not show until the next frame
            if (n == FRAME + 100 * H_TOT) pattern_en = 1'b1;
            tick();
        end
        tests++;
        if (bad_hlines != 0) begin
            fails++;
            $display("FAIL hsync_width: %0d lines without 96 low clocks, want 0", bad_hlines);
        end
        tests++;
        if (sig_err != 0) begin
            fails++;
            $display("FAIL signal_window: %0d bad cycles, first at h=%0d v=%0d, want 0", sig_err, err_h, err_v);
        end
        tests++;
        if (fs_count != 2 || last_fs != FRAME) begin
            fails++;
            $display("FAIL frame_start_period: %0d pulses, last at %0d, want 2 and %0d", fs_count, last_fs, FRAME);
        end
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL frame_start_third: got %b at clock %0d, want 1", frame_start, 2 * FRAME);
        end
    endtask

    // Frame after pattern_en rose: colour bars regardless of pix_data
    task automatic test_pattern();
        int bar_err [8];
        int de_cnt = 0;
        int x;
        foreach (bar_err[i]) bar_err[i] = 0;
        pix_data = 16'h1234;
        run_to(0, 35);
        for (int n = 0; n < 3 * H_TOT; n++) begin
            if (de === 1'b1) begin
                de_cnt++;
                x = hm - 144;
                if (x >= 0 && x < 640 && rgb !== bars[x / 80]) bar_err[x / 80]++;
            end
            tick();
        end
        tests++;
        if (de_cnt != 3 * 640) begin
            fails++;
            $display("FAIL pattern_de_count: got %0d, want %0d", de_cnt, 3 * 640);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if (bar_err[b] != 0) begin
                fails++;
                $display("FAIL pattern_bar%0d: %0d wrong pixels, want 0 (colour %h)", b, bar_err[b], bars[b]);
            end
        end
    endtask

    // Ten-clock blank pulse inside active video
    task automatic test_blank();
        logic [15:0] e_rgb;
        run_to(296, 40);
        for (int i = 0; i < 20; i++) begin
            if (hm == 300) blank = 1'b1;
            if (hm == 310) blank = 1'b0;
            #1;
            e_rgb = (hm >= 300 && hm < 310) ? 16'h0000 : bars[(hm - 144) / 80];
            tests++;
            if ({rgb, hsync, de} !== {e_rgb, 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL blank_h%0d: rgb=%h hs=%b de=%b, want rgb=%h hs=1 de=1", hm, rgb, hsync, de, e_rgb);
            end
            tick();
        end
        blank = 1'b0;
    endtask

    // Reset mid-frame, then a clean restart from 0,0 with pattern mode cleared
    task automatic test_mid_reset();
        run_to(400, 200);
        pattern_en = 1'b0;
        sys_rst = 1'b1;
        track = 1'b0;
        repeat (3) begin
            tick();
            tests++;
            if ({hsync, vsync, de, pix_req, frame_start, pix_x, pix_y, rgb} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000}) begin
                fails++;
                $display("FAIL midreset_values: hs=%b vs=%b de=%b req=%b fs=%b x=%h y=%h rgb=%h, want 1 1 0 0 0 3ff 3ff 0000",
                         hsync, vsync, de, pix_req, frame_start, pix_x, pix_y, rgb);
            end
        end
        sys_rst = 1'b0;
        tick();
        hm = 0;
        vm = 0;
        track = 1'b1;
        tests++;
        if ({frame_start, hsync, vsync, de} !== 4'b1000) begin
            fails++;
            $display("FAIL restart_first: fs/hs/vs/de=%b want 1000", {frame_start, hsync, vsync, de});
        end
        run_to(95, 0);
        tests++;
        if (hsync !== 1'b0) begin
            fails++;
            $display("FAIL restart_hsync95: got %b want 0", hsync);
        end
        tick();
        tests++;
        if (hsync !== 1'b1) begin
            fails++;
            $display("FAIL restart_hsync96: got %b want 1", hsync);
        end
        run_to(143, 35);
        tests++;
        if ({pix_req, de, pix_x, pix_y} !== {1'b1, 1'b0, 10'd0, 10'd0}) begin
            fails++;
            $display("FAIL restart_req: req=%b de=%b x=%0d y=%0d, want 1 0 0 0", pix_req, de, pix_x, pix_y);
        end
        tick();
        tests++;
        if ({de, rgb} !== {1'b1, 16'h1234}) begin
            fails++;
            $display("FAIL restart_rgb: de=%b rgb=%h, want 1 1234", de, rgb);
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_pattern();
        test_blank();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
